// File: rtl/axis_uart_rx.sv
// UART receiver: 16x oversampling, 3-sample majority vote, optional parity,
// 1 or 2 stop bits, and an AXI4-Stream master fed from a small FIFO.
module axis_uart_rx #(
  parameter int CLK_FREQ   = 18_432_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic [1:0]           m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 overrun
);
  localparam int OS_DIV = CLK_FREQ / (BAUD * 16);
  localparam int PW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int FW     = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state, state_next;

  logic                 rx_meta, rx_s, rx_d;
  logic [PW-1:0]        pre_cnt;
  logic                 tick;
  logic [3:0]           os_cnt, bit_cnt;
  logic                 s7, s8, vote, vote_tick, wrap_tick;
  logic                 last_data, last_stop, parity_exp;
  logic [DATA_BITS-1:0] data;
  logic                 perr, ferr, frame_done;
  logic                 push_valid;
  logic [FW-1:0]        push_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      // NOTE: sequential state always uses <= so every flop sees pre-edge values.
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign tick       = (state != S_IDLE) && (pre_cnt == PW'(OS_DIV - 1));
  assign vote_tick  = tick && (os_cnt == 4'd9);
  assign wrap_tick  = tick && (os_cnt == 4'd15);
  assign vote       = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign last_data  = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop  = (bit_cnt == 4'(STOP_BITS - 1));
  assign parity_exp = (PARITY == 2) ? ~^data : ^data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // A break ends with rx_s still low, so no falling edge exists until the
  // line has gone high again; the edge detector alone blocks repeat frames.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_next = state;
    frame_done = 1'b0;
    case (state)
      S_IDLE:   if (rx_d && !rx_s) state_next = S_START;
      S_START: begin
        if (vote_tick && vote) state_next = S_IDLE;
        else if (wrap_tick)    state_next = S_DATA;
      end
      S_DATA:   if (wrap_tick && last_data) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (wrap_tick) state_next = S_STOP;
      S_STOP: begin
        if (vote_tick && last_stop) begin
          state_next = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt    <= '0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      s7         <= 1'b1;
      s8         <= 1'b1;
      data       <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      push_valid <= 1'b0;
      push_frame <= '0;
    end else begin
      push_valid <= frame_done;
      // The final stop vote lands in the same cycle, so fold it in directly.
      if (frame_done) push_frame <= {perr, ferr | ~vote, data};
      if (state == S_IDLE) begin
        pre_cnt <= '0;
        os_cnt  <= '0;
        bit_cnt <= '0;
        perr    <= 1'b0;
        ferr    <= 1'b0;
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (tick) begin
          os_cnt <= os_cnt + 1'b1;
          if (os_cnt == 4'd7) s7 <= rx_s;
          if (os_cnt == 4'd8) s8 <= rx_s;
        end
        if (wrap_tick) bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
        if (vote_tick) begin
          case (state)
            S_DATA:   data <= {vote, data[DATA_BITS-1:1]};
            S_PARITY: if (vote != parity_exp) perr <= 1'b1;
            S_STOP:   if (!vote) ferr <= 1'b1;
            default:  ;
          endcase
        end
      end
    end
  end

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic          empty, full, pop, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = m_axis_tvalid & m_axis_tready;
  assign push_ok = push_valid & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      overrun <= push_valid & ~push_ok;
    end
  end

  // NOTE: storage is deliberately unreset; outputs are gated by tvalid, so stale entries never show.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_frame;
  end

  assign m_axis_tvalid = ~empty;
  assign {m_axis_tuser, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Bench for axis_uart_rx: three parity/stop configurations driven with directed
// frames; a frame-level model queues expected beats and one process compares.
`timescale 1ns/1ps
module tb_axis_uart_rx;
  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx     [3];
  logic       tready [3];
  logic [7:0] tdata  [3];
  logic [1:0] tuser  [3];
  logic       tvalid [3];
  logic       ovr    [3];

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q [3][$];
  int exp_ovr  [3];
  int ovr_seen [3];
  logic       prev_hold [3];
  logic       prev_ovr  [3];
  logic [9:0] prev_beat [3];

  always #5 clk = ~clk;

  axis_uart_rx #(.PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .m_axis_tdata(tdata[0]), .m_axis_tuser(tuser[0]),
    .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]), .overrun(ovr[0]));
  axis_uart_rx #(.PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .m_axis_tdata(tdata[1]), .m_axis_tuser(tuser[1]),
    .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]), .overrun(ovr[1]));
  axis_uart_rx #(.PARITY(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .m_axis_tdata(tdata[2]), .m_axis_tuser(tuser[2]),
    .m_axis_tvalid(tvalid[2]), .m_axis_tready(tready[2]), .overrun(ovr[2]));

  function automatic int par_mode(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 2;
  endfunction

  function automatic int stop_n(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  // Error tag a correct receiver must report for the given line content.
  function automatic logic [1:0] model_tag(input int k, input logic [7:0] d, input logic pbit,
                                           input logic st1, input logic st2);
    logic perr, ferr;
    perr = 1'b0;
    if (par_mode(k) == 1)      perr = (pbit != ^d);
    else if (par_mode(k) == 2) perr = (pbit != ~^d);
    ferr = !st1 || (stop_n(k) == 2 && !st2);
    return {perr, ferr};
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h, want %0h", name, k, act, req);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input logic pbit, input logic st1,
                            input logic st2, input logic [1:0] pin, input int spike_bit);
    logic [1:0] tag;
    rx[k] = 1'b0;
    ticks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx[k] = d[i];
      if (i == spike_bit) begin
        ticks(90);
        rx[k] = ~d[i];
        ticks(1);
        rx[k] = d[i];
        ticks(BIT - 91);
      end else begin
        ticks(BIT);
      end
    end
    if (par_mode(k) != 0) begin
      rx[k] = pbit;
      ticks(BIT);
    end
    tag = model_tag(k, d, pbit, st1, st2);
    check("model_pin", k, 32'(tag), 32'(pin));
    if (exp_q[k].size() >= 4 && !tready[k]) exp_ovr[k]++;
    else exp_q[k].push_back({tag, d});
    rx[k] = st1;
    ticks(BIT);
    if (stop_n(k) == 2) begin
      rx[k] = st2;
      ticks(BIT);
    end
    rx[k] = 1'b1;
    ticks(2 * BIT);
  endtask

  task automatic send_break(input int k, input int cycles);
    logic [1:0] tag;
    tag = model_tag(k, 8'h00, 1'b0, 1'b0, 1'b0);
    check("model_pin_break", k, 32'(tag), 32'h1);
    exp_q[k].push_back({tag, 8'h00});
    rx[k] = 1'b0;
    ticks(cycles);
    rx[k] = 1'b1;
    ticks(2 * BIT);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) check("queue_drained", k, exp_q[k].size(), 0);
  endtask

  always begin
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        prev_hold[k] = 1'b0;
        prev_ovr[k]  = 1'b0;
      end else begin
        if (prev_hold[k]) begin
          check("hold_valid", k, 32'(tvalid[k]), 32'h1);
          check("hold_data", k, 32'({tuser[k], tdata[k]}), 32'(prev_beat[k]));
        end
        if (tvalid[k] && tready[k]) begin
          check("beat_pending", k, 32'(exp_q[k].size() > 0), 32'h1);
          if (exp_q[k].size() > 0) begin
            logic [9:0] e;
            e = exp_q[k].pop_front();
            check("beat_tdata", k, 32'(tdata[k]), 32'(e[7:0]));
            check("beat_tuser", k, 32'(tuser[k]), 32'(e[9:8]));
          end
        end
        if (ovr[k]) begin
          ovr_seen[k]++;
          check("overrun_width", k, 32'(prev_ovr[k]), 32'h0);
        end
        prev_hold[k] = tvalid[k] && !tready[k];
        prev_beat[k] = {tuser[k], tdata[k]};
        prev_ovr[k]  = ovr[k];
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rx[k]       = 1'b1;
      tready[k]   = 1'b1;
      exp_ovr[k]  = 0;
      ovr_seen[k] = 0;
    end
    rst = 1'b1;
    ticks(3);
    for (int k = 0; k < 3; k++) begin
      check("rst_tvalid", k, 32'(tvalid[k]), 32'h0);
      check("rst_tdata", k, 32'(tdata[k]), 32'h0);
      check("rst_tuser", k, 32'(tuser[k]), 32'h0);
      check("rst_overrun", k, 32'(ovr[k]), 32'h0);
    end
    rst = 1'b0;
    ticks(20);

    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 2'b00, -1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 2'b00, -1);
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1, 2'b10, -1);
    send_frame(2, 8'h3C, 1'b1, 1'b1, 1'b0, 2'b01, -1);

    // Short low pulse must be rejected as a false start.
    rx[0] = 1'b0;
    ticks(40);
    rx[0] = 1'b1;
    ticks(3 * BIT);
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 2'b00, 1);
    drain();

    tready[0] = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b1, 1'b1, 2'b00, -1);
    check("model_overrun", 0, exp_ovr[0], 1);
    tready[0] = 1'b1;
    drain();

    // Reset mid-frame with one entry pending: both must vanish.
    tready[0] = 1'b0;
    send_frame(0, 8'h99, 1'b0, 1'b1, 1'b1, 2'b00, -1);
    rx[0] = 1'b0;
    ticks(BIT);
    rx[0] = 1'b1;
    ticks(4 * BIT + BIT / 2);
    rst = 1'b1;
    #1;
    check("rst_mid_tvalid", 0, 32'(tvalid[0]), 32'h0);
    exp_q[0].delete();
    ticks(4);
    rst = 1'b0;
    tready[0] = 1'b1;
    ticks(3 * BIT);
    send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1, 2'b00, -1);
    drain();

    send_break(0, 30 * BIT);
    ticks(4 * BIT);
    drain();

    for (int k = 0; k < 3; k++) check("overrun_count", k, ovr_seen[k], exp_ovr[k]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
